// File: rtl/wb_fpga_cfg_loader_if.sv
// Management Wishbone bus as seen by the configuration loader slave.
interface wb_fpga_cfg_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_fpga_cfg_loader.sv
// Wishbone-programmed FPGA configuration loader: buffers 32-bit words in a FIFO and
// shifts them MSB-first onto the fabric configuration chain under a divided shift clock.
module wb_fpga_cfg_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  wb_fpga_cfg_loader_if.slave wbs,
  output logic                cfg_clk_o,
  output logic                cfg_data_o,
  output logic                cfg_en_o,
  output logic                cfg_done_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   FifoFull = FIFO_DEPTH[AW:0];

  localparam logic [7:0] OffCtrl   = 8'h00;
  localparam logic [7:0] OffStatus = 8'h04;
  localparam logic [7:0] OffData   = 8'h08;
  localparam logic [7:0] OffBitcnt = 8'h0C;

  typedef enum logic [1:0] {StIdle, StLoad, StLo, StHi} state_e;

  // Bus decode
  logic        w_hit;
  logic        w_acc;
  logic        w_wr;
  logic        w_data_wr;
  logic        w_stall;
  logic        w_push;
  logic        w_ctrl_wr;
  logic        w_abort;
  logic        w_go;
  logic        w_fin;
  logic [31:0] w_rdata;
  logic        w_unused_sel;

  // FIFO
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [31:0]   w_count32;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [31:0]   w_head;

  // Control and shifter
  state_e        r_state;
  logic [31:0]   r_sr;
  logic [5:0]    r_bits_left;
  logic [DW-1:0] r_div;
  logic          r_cfg_clk;
  logic          r_cfg_data;
  logic          r_enable;
  logic          r_finish;
  logic          r_done;
  logic [31:0]   r_bitcnt;
  logic          r_ack;
  logic [31:0]   r_dat;
  logic          w_busy;

  assign w_unused_sel = ^wbs.wbs_sel_i;

  assign w_hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_acc     = w_hit & ~r_ack;
  assign w_wr      = w_acc & wbs.wbs_we_i;
  assign w_data_wr = w_wr & (wbs.wbs_adr_i[7:0] == OffData);
  // Full is sampled before this cycle's pop, so a stalled write lands one cycle after a pop.
  assign w_stall   = w_data_wr & w_full;
  assign w_push    = w_data_wr & ~w_full;
  assign w_ctrl_wr = w_wr & (wbs.wbs_adr_i[7:0] == OffCtrl);
  assign w_abort   = w_ctrl_wr & wbs.wbs_dat_i[2];
  assign w_go      = w_ctrl_wr & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[2];
  assign w_fin     = w_ctrl_wr & wbs.wbs_dat_i[1] & ~wbs.wbs_dat_i[2];

  assign w_full    = (r_count == FifoFull);
  assign w_empty   = (r_count == '0);
  assign w_pop     = (r_state == StLoad) & ~w_empty;
  assign w_head    = r_mem[r_rptr];
  assign w_count32 = 32'(r_count);
  assign w_busy    = (r_state != StIdle);

  always_comb begin
    w_rdata = '0;
    case (wbs.wbs_adr_i[7:0])
      OffCtrl:   w_rdata = {29'b0, 1'b0, r_finish, r_enable};
      OffStatus: w_rdata = {24'b0, w_count32[3:0], r_done, w_empty, w_full, w_busy};
      OffBitcnt: w_rdata = r_bitcnt;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc & ~w_stall;
      r_dat <= (w_acc & ~wbs.wbs_we_i) ? w_rdata : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= wbs.wbs_dat_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_abort) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_sr        <= '0;
      r_bits_left <= '0;
      r_div       <= '0;
      r_cfg_clk   <= 1'b0;
      r_cfg_data  <= 1'b0;
      r_enable    <= 1'b0;
      r_finish    <= 1'b0;
      r_done      <= 1'b0;
      r_bitcnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_enable && !w_empty) begin
            r_state <= StLoad;
          end else if (r_finish && w_empty) begin
            r_done   <= 1'b1;
            r_finish <= 1'b0;
            r_enable <= 1'b0;
          end
        end
        StLoad: begin
          r_sr        <= w_head;
          r_cfg_data  <= w_head[31];
          r_bits_left <= 6'd32;
          r_div       <= '0;
          r_state     <= StLo;
        end
        StLo: begin
          if (r_div == DivLast) begin
            r_div     <= '0;
            r_cfg_clk <= 1'b1;
            r_state   <= StHi;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StHi: begin
          if (r_div == DivLast) begin
            r_div       <= '0;
            r_cfg_clk   <= 1'b0;
            r_sr        <= r_sr << 1;
            r_bitcnt    <= r_bitcnt + 32'd1;
            r_bits_left <= r_bits_left - 6'd1;
            if (r_bits_left == 6'd1) begin
              r_state <= (!w_empty && r_enable) ? StLoad : StIdle;
            end else begin
              r_cfg_data <= r_sr[30];
              r_state    <= StLo;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
      endcase

      // Firmware writes override the sequencer; ABORT discards any partial word.
      if (w_abort) begin
        r_state   <= StIdle;
        r_enable  <= 1'b0;
        r_finish  <= 1'b0;
        r_cfg_clk <= 1'b0;
        r_div     <= '0;
      end else begin
        if (w_go) begin
          r_enable <= 1'b1;
          r_done   <= 1'b0;
          r_bitcnt <= '0;
        end
        if (w_fin) begin
          r_finish <= 1'b1;
        end
      end
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign cfg_clk_o     = r_cfg_clk;
  assign cfg_data_o    = r_cfg_data;
  assign cfg_en_o      = r_enable;
  assign cfg_done_o    = r_done;

endmodule
